vending_machine_param: RTL and testbench
========================================

VENDING_MACHINE_PARAM -- requirements
Module: vending_machine_param

Interface
REQ-001 SHALL have parameter W, default 8, meaning credit/price/change datapath width in bits.
REQ-002 SHALL have parameter N_ITEMS, default 4, meaning number of selectable item channels (>=2).
REQ-003 SHALL have parameter PRICES, default {8'd100,8'd75,8'd50,8'd25}, meaning packed N_ITEMS*W vector; item i price = PRICES[i*W +: W], each nonzero.
REQ-004 SHALL have parameter COIN_VAL, default {8'd100,8'd25,8'd10,8'd5}, meaning packed 4*W vector; coin_type k value = COIN_VAL[k*W +: W].
REQ-005 SHALL have parameter MAX_CREDIT, default 8'd200, meaning the credit ceiling (<= 2^W-1).
REQ-006 SHALL use one clock, clk, rising-edge; reset is asynchronous and active-low, named rst.
REQ-007 Ports: clk  in  1  clock; rst  in  1  async active-low reset.
REQ-008 Ports: coin_valid  in  1  coin inserted this cycle; coin_type  in  2  denomination index.
REQ-009 Ports: sel_valid  in  1  selection request; sel  in  $clog2(N_ITEMS)  item index; cancel  in  1  refund request.
REQ-010 Ports: stock_empty  in  N_ITEMS  per-item sold-out flag.
REQ-011 Ports: dispense  out  1  one-cycle vend pulse; dispense_id  out  $clog2(N_ITEMS)  vended item.
REQ-012 Ports: change_valid  out  1  one-cycle change pulse; change_amt  out  W  change value.
REQ-013 Ports: coin_reject  out  1  one-cycle coin-return pulse; sel_err  out  1  one-cycle selection-fail pulse; credit  out  W  current credit; busy  out  1  high in VEND/CHANGE.

Function
REQ-014 SHALL implement FSM states IDLE (credit=0), CREDIT (credit>0), VEND, CHANGE; all outputs registered.
REQ-015 Input priority per cycle SHALL be cancel > sel_valid > coin_valid; a coin arriving with accepted cancel or sel_valid SHALL produce coin_reject next cycle, credit unchanged.
REQ-016 IDLE/CREDIT, coin only: if credit+value <= MAX_CREDIT, credit SHALL increase by value next cycle and state -> CREDIT; else coin_reject=1 next cycle, credit unchanged.
REQ-017 Credit addition SHALL use W+1-bit arithmetic; credit SHALL never wrap or exceed MAX_CREDIT.
REQ-018 Selection with sel >= N_ITEMS, stock_empty[sel]=1, or credit < price SHALL give sel_err=1 next cycle, credit and state unchanged.
REQ-019 Valid selection SHALL enter VEND: next cycle dispense=1, dispense_id=sel, busy=1, credit reduced by price.
REQ-020 VEND SHALL always go to CHANGE next cycle; CHANGE with remaining credit>0 SHALL assert change_valid=1, change_amt=remaining credit for one cycle, then credit=0 and IDLE.
REQ-021 CHANGE with remaining credit=0 SHALL assert no change_valid and go to IDLE; busy high for both VEND and CHANGE cycles (2-cycle vend latency, selection to IDLE).
REQ-022 Cancel in CREDIT SHALL go directly to IDLE with change_valid=1, change_amt=credit, credit=0 next cycle; cancel in IDLE SHALL have no effect.
REQ-023 While busy, cancel and sel_valid SHALL be ignored and any coin_valid SHALL produce coin_reject next cycle.
REQ-024 change_amt SHALL read 0 whenever change_valid=0; dispense_id SHALL hold its last value when dispense=0.

Reset
REQ-025 rst low SHALL immediately force IDLE, credit=0, dispense=0, dispense_id=0, change_valid=0, change_amt=0, coin_reject=0, sel_err=0, busy=0.
REQ-026 Reset during VEND/CHANGE SHALL abort without pulsing change_valid; pending credit is discarded.
REQ-027 First state update SHALL occur on the first rising clk edge after rst deasserts.

Verification
REQ-028 Defaults: coins 25,25,25 then sel=2 -> credit 75, dispense=1 id=2, next cycle no change_valid, IDLE.
REQ-029 Coin 100, sel=0 -> dispense id=0, then change_valid=1 change_amt=75, credit=0.
REQ-030 Coins 100,100, then coin 5 -> coin_reject=1, credit stays 200; cancel -> change_amt=200.
REQ-031 Credit 10, sel=1 -> sel_err=1 credit 10; stock_empty[3]=1, credit 100, sel=3 -> sel_err=1.
REQ-032 Coin 25 with sel_valid same cycle at credit 50, sel=1 -> dispense id=1, coin_reject=1, change_amt 0 absent; coin during busy -> coin_reject.
REQ-033 rst low mid-CHANGE -> all outputs 0 immediately, no change pulse, IDLE after release.

Source files
------------

// File: rtl/vending_machine_param.sv
// Parameterised vending controller: accumulates coin credit up to a ceiling,
// vends a selected item, returns change, and refunds on cancel.
module vending_machine_param #(
  parameter int                       W          = 8,
  parameter int                       N_ITEMS    = 4,
  parameter logic [N_ITEMS*W-1:0]     PRICES     = {8'd100, 8'd75, 8'd50, 8'd25},
  parameter logic [4*W-1:0]           COIN_VAL   = {8'd100, 8'd25, 8'd10, 8'd5},
  parameter logic [W-1:0]             MAX_CREDIT = 8'd200,
  localparam int                      SEL_W      = $clog2(N_ITEMS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               coin_valid,
  input  logic [1:0]         coin_type,
  input  logic               sel_valid,
  input  logic [SEL_W-1:0]   sel,
  input  logic               cancel,
  input  logic [N_ITEMS-1:0] stock_empty,
  output logic               dispense,
  output logic [SEL_W-1:0]   dispense_id,
  output logic               change_valid,
  output logic [W-1:0]       change_amt,
  output logic               coin_reject,
  output logic               sel_err,
  output logic [W-1:0]       credit,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       credit_q, credit_d;
  logic               dispense_q, dispense_d;
  logic [SEL_W-1:0]   id_q, id_d;
  logic               chg_vld_q, chg_vld_d;
  logic [W-1:0]       chg_amt_q, chg_amt_d;
  logic               rej_q, rej_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  logic [W-1:0]       coin_amt;
  logic [W-1:0]       price;
  logic               sel_hit;
  logic               sel_empty;

  // Widened sum so that an over-ceiling insertion can never wrap back into range.
  function automatic logic fits_credit(input logic [W-1:0] cur, input logic [W-1:0] add);
    logic [W:0] sum;
    sum = {1'b0, cur} + {1'b0, add};
    return sum <= {1'b0, MAX_CREDIT};
  endfunction

  always_comb begin
    coin_amt  = '0;
    price     = '0;
    sel_hit   = 1'b0;
    sel_empty = 1'b0;
    for (int k = 0; k < 4; k++)
      if (coin_type == 2'(k)) coin_amt = COIN_VAL[k*W +: W];
    for (int i = 0; i < N_ITEMS; i++)
      if (sel == SEL_W'(i)) begin
        sel_hit   = 1'b1;
        price     = PRICES[i*W +: W];
        sel_empty = stock_empty[i];
      end
  end

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    dispense_d = 1'b0;
    id_d       = id_q;
    chg_vld_d  = 1'b0;
    chg_amt_d  = '0;
    rej_d      = 1'b0;
    err_d      = 1'b0;
    busy_d     = 1'b0;
    unique case (state_q)
      IDLE, CREDIT: begin
        if (cancel && state_q == CREDIT) begin
          state_d   = IDLE;
          chg_vld_d = 1'b1;
          chg_amt_d = credit_q;
          credit_d  = '0;
          rej_d     = coin_valid;
        end else if (sel_valid) begin
          rej_d = coin_valid;
          if (!sel_hit || sel_empty || credit_q < price) begin
            err_d = 1'b1;
          end else begin
            state_d    = VEND;
            dispense_d = 1'b1;
            id_d       = sel;
            busy_d     = 1'b1;
            credit_d   = credit_q - price;
          end
        end else if (coin_valid) begin
          if (fits_credit(credit_q, coin_amt)) begin
            credit_d = credit_q + coin_amt;
            state_d  = CREDIT;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      VEND: begin
        // Change pulse is launched here so it is visible during the CHANGE cycle.
        state_d  = CHANGE;
        busy_d   = 1'b1;
        rej_d    = coin_valid;
        credit_d = '0;
        if (credit_q != '0) begin
          chg_vld_d = 1'b1;
          chg_amt_d = credit_q;
        end
      end
      CHANGE: begin
        state_d  = IDLE;
        rej_d    = coin_valid;
        credit_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      dispense_q <= 1'b0;
      id_q       <= '0;
      chg_vld_q  <= 1'b0;
      chg_amt_q  <= '0;
      rej_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      dispense_q <= dispense_d;
      id_q       <= id_d;
      chg_vld_q  <= chg_vld_d;
      chg_amt_q  <= chg_amt_d;
      rej_q      <= rej_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign dispense     = dispense_q;
  assign dispense_id  = id_q;
  assign change_valid = chg_vld_q;
  assign change_amt   = chg_amt_q;
  assign coin_reject  = rej_q;
  assign sel_err      = err_q;
  assign credit       = credit_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for vending_machine_param with default parameters
// (coins 5/10/25/100, item prices 25/50/75/100).
module tb_vending_machine_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_valid, sel_valid, cancel;
  logic [1:0] coin_type, sel;
  logic [3:0] stock_empty;
  logic       dispense, change_valid, coin_reject, sel_err, busy;
  logic [1:0] dispense_id;
  logic [7:0] change_amt, credit;

  int errors = 0;
  int checks = 0;

  vending_machine_param dut (
    .clk(clk), .rst(rst),
    .coin_valid(coin_valid), .coin_type(coin_type),
    .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
    .stock_empty(stock_empty),
    .dispense(dispense), .dispense_id(dispense_id),
    .change_valid(change_valid), .change_amt(change_amt),
    .coin_reject(coin_reject), .sel_err(sel_err),
    .credit(credit), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cycle(input logic cv, input logic [1:0] ct, input logic sv,
                       input logic [1:0] s, input logic cn);
    coin_valid = cv; coin_type = ct; sel_valid = sv; sel = s; cancel = cn;
    @(posedge clk); #1;
    coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({dispense, dispense_id, change_valid, change_amt, coin_reject, sel_err, credit, busy} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0",
               {dispense, dispense_id, change_valid, change_amt, coin_reject, sel_err, credit, busy});
    end
  endtask

  task automatic test_exact_vend;
    cycle(1, 2'd2, 0, 0, 0);
    cycle(1, 2'd2, 0, 0, 0);
    cycle(1, 2'd2, 0, 0, 0);
    checks++;
    if (credit !== 8'd75) begin errors++; $display("FAIL exact_credit got=%0d exp=75", credit); end
    cycle(0, 0, 1, 2'd2, 0);
    checks++;
    if ({dispense, dispense_id, busy, credit} !== {1'b1, 2'd2, 1'b1, 8'd0}) begin
      errors++; $display("FAIL exact_vend disp=%b id=%0d busy=%b credit=%0d exp 1/2/1/0", dispense, dispense_id, busy, credit);
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if ({busy, change_valid, change_amt, dispense} !== {1'b1, 1'b0, 8'd0, 1'b0}) begin
      errors++; $display("FAIL exact_nochange busy=%b cv=%b amt=%0d disp=%b exp 1/0/0/0", busy, change_valid, change_amt, dispense);
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if ({busy, dispense_id} !== {1'b0, 2'd2}) begin
      errors++; $display("FAIL exact_idle busy=%b id=%0d exp 0/2", busy, dispense_id);
    end
  endtask

  task automatic test_change;
    cycle(1, 2'd3, 0, 0, 0);
    cycle(0, 0, 1, 2'd0, 0);
    checks++;
    if ({dispense, dispense_id, credit} !== {1'b1, 2'd0, 8'd75}) begin
      errors++; $display("FAIL change_vend disp=%b id=%0d credit=%0d exp 1/0/75", dispense, dispense_id, credit);
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if ({change_valid, change_amt, credit, busy} !== {1'b1, 8'd75, 8'd0, 1'b1}) begin
      errors++; $display("FAIL change_pulse cv=%b amt=%0d credit=%0d busy=%b exp 1/75/0/1", change_valid, change_amt, credit, busy);
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if ({change_valid, change_amt, busy} !== {1'b0, 8'd0, 1'b0}) begin
      errors++; $display("FAIL change_end cv=%b amt=%0d busy=%b exp 0/0/0", change_valid, change_amt, busy);
    end
  endtask

  task automatic test_overflow_cancel;
    cycle(1, 2'd3, 0, 0, 0);
    cycle(1, 2'd3, 0, 0, 0);
    cycle(1, 2'd0, 0, 0, 0);
    checks++;
    if ({coin_reject, credit} !== {1'b1, 8'd200}) begin
      errors++; $display("FAIL overflow_reject rej=%b credit=%0d exp 1/200", coin_reject, credit);
    end
    cycle(0, 0, 0, 0, 1);
    checks++;
    if ({change_valid, change_amt, credit, busy, coin_reject} !== {1'b1, 8'd200, 8'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL cancel_refund cv=%b amt=%0d credit=%0d busy=%b rej=%b exp 1/200/0/0/0",
                         change_valid, change_amt, credit, busy, coin_reject);
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if ({change_valid, change_amt} !== {1'b0, 8'd0}) begin
      errors++; $display("FAIL cancel_clear cv=%b amt=%0d exp 0/0", change_valid, change_amt);
    end
  endtask

  task automatic test_idle_cancel;
    cycle(0, 0, 0, 0, 1);
    checks++;
    if ({change_valid, credit, busy} !== {1'b0, 8'd0, 1'b0}) begin
      errors++; $display("FAIL idle_cancel cv=%b credit=%0d busy=%b exp 0/0/0", change_valid, credit, busy);
    end
  endtask

  task automatic test_sel_err;
    cycle(1, 2'd1, 0, 0, 0);
    cycle(0, 0, 1, 2'd1, 0);
    checks++;
    if ({sel_err, credit, dispense, busy} !== {1'b1, 8'd10, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sel_err_price err=%b credit=%0d disp=%b busy=%b exp 1/10/0/0", sel_err, credit, dispense, busy);
    end
    cycle(0, 0, 0, 0, 1);
    checks++;
    if ({sel_err, change_valid, change_amt} !== {1'b0, 1'b1, 8'd10}) begin
      errors++; $display("FAIL sel_err_refund err=%b cv=%b amt=%0d exp 0/1/10", sel_err, change_valid, change_amt);
    end
    stock_empty = 4'b1000;
    cycle(1, 2'd3, 0, 0, 0);
    cycle(0, 0, 1, 2'd3, 0);
    checks++;
    if ({sel_err, credit, dispense} !== {1'b1, 8'd100, 1'b0}) begin
      errors++; $display("FAIL sel_err_stock err=%b credit=%0d disp=%b exp 1/100/0", sel_err, credit, dispense);
    end
    cycle(0, 0, 0, 0, 1);
    checks++;
    if ({change_valid, change_amt} !== {1'b1, 8'd100}) begin
      errors++; $display("FAIL stock_refund cv=%b amt=%0d exp 1/100", change_valid, change_amt);
    end
    stock_empty = 4'b0000;
  endtask

  task automatic test_coin_with_sel_and_busy;
    cycle(1, 2'd2, 0, 0, 0);
    cycle(1, 2'd2, 0, 0, 0);
    cycle(1, 2'd2, 1, 2'd1, 0);
    checks++;
    if ({dispense, dispense_id, coin_reject, credit} !== {1'b1, 2'd1, 1'b1, 8'd0}) begin
      errors++; $display("FAIL coin_sel disp=%b id=%0d rej=%b credit=%0d exp 1/1/1/0", dispense, dispense_id, coin_reject, credit);
    end
    cycle(1, 2'd3, 0, 0, 0);
    checks++;
    if ({busy, coin_reject, change_valid, credit} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
      errors++; $display("FAIL busy_coin busy=%b rej=%b cv=%b credit=%0d exp 1/1/0/0", busy, coin_reject, change_valid, credit);
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if ({busy, coin_reject, credit} !== {1'b0, 1'b0, 8'd0}) begin
      errors++; $display("FAIL busy_done busy=%b rej=%b credit=%0d exp 0/0/0", busy, coin_reject, credit);
    end
  endtask

  task automatic test_reset_mid_vend;
    cycle(1, 2'd3, 0, 0, 0);
    cycle(0, 0, 1, 2'd1, 0);
    checks++;
    if ({busy, dispense, credit} !== {1'b1, 1'b1, 8'd50}) begin
      errors++; $display("FAIL pre_abort busy=%b disp=%b credit=%0d exp 1/1/50", busy, dispense, credit);
    end
    #2 rst = 1'b0;
    #1;
    test_reset();
    #2 rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({change_valid, change_amt, busy, credit} !== {1'b0, 8'd0, 1'b0, 8'd0}) begin
      errors++; $display("FAIL abort_no_change cv=%b amt=%0d busy=%b credit=%0d exp 0/0/0/0", change_valid, change_amt, busy, credit);
    end
    cycle(1, 2'd0, 0, 0, 0);
    checks++;
    if (credit !== 8'd5) begin errors++; $display("FAIL post_abort_coin credit=%0d exp 5", credit); end
  endtask

  initial begin
    rst = 1'b0;
    coin_valid = 1'b0; coin_type = '0; sel_valid = 1'b0; sel = '0; cancel = 1'b0;
    stock_empty = '0;
    #1;
    test_reset();
    #12 rst = 1'b1;
    @(posedge clk); #1;
    test_exact_vend();
    test_change();
    test_overflow_cancel();
    test_idle_cancel();
    test_sel_err();
    test_coin_with_sel_and_busy();
    test_reset_mid_vend();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
